// File: rtl/jttrack_pkg.sv
// jttrack_pkg
// Shared constants and helpers for the Track'n Field final colour stage.
//   - Palette byte field positions (red / green / blue LSBs)
//   - Palette address bit that selects the object half of the PROM
//   - gfx_en bit indices for the debug layer enables
//   - Colour expansion helpers (3-bit and 2-bit to 4-bit)
package jttrack_pkg;

    localparam int R_LSB   = 0;
    localparam int G_LSB   = 3;
    localparam int B_LSB   = 6;

    localparam int OBJ_BIT = 4;

    localparam int GFX_SCR = 0;
    localparam int GFX_OBJ = 3;

    localparam int PAL_AW  = 5;
    localparam int PAL_DW  = 8;

    // Replicate the MSB into the new LSB so full scale stays full scale
    function automatic logic [3:0] expand3(input logic [2:0] v);
        return {v, v[2]};
    endfunction

    // Duplicate the 2-bit value to cover the whole 4-bit range
    function automatic logic [3:0] expand2(input logic [1:0] v);
        return {v, v};
    endfunction

endpackage

// File: rtl/jtframe_sh.sv
// jtframe_sh
// Clock-enabled shift register, used as the blanking delay line.
// Ports:
//   clk_i  - system clock
//   rst_i  - asynchronous active-high reset, clears every stage
//   cen_i  - shift enable; the line only advances when high
//   din_i  - W-bit input, sampled into stage 0
//   drop_o - W-bit output, the last stage (input delayed L enabled ticks)
module jtframe_sh #(
    parameter int W = 2,
    parameter int L = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         cen_i,
    input  logic [W-1:0] din_i,
    output logic [W-1:0] drop_o
);

    logic [W-1:0] sh_q [0:L-1];

    // Delay line: stage 0 takes the input, each later stage takes its predecessor
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < L; i++) begin
                sh_q[i] <= '0;
            end
        end else if (cen_i) begin
            sh_q[0] <= din_i;
            for (int i = 1; i < L; i++) begin
                sh_q[i] <= sh_q[i-1];
            end
        end
    end

    assign drop_o = sh_q[L-1];

endmodule

// File: rtl/jttrack_colmix.sv
// jttrack_colmix
// Final colour stage: masks the scroll/object layers, resolves object-over-
// scroll priority, looks the winner up in the 32x8 colour PROM and expands it
// to 4-bit RGB. Blanking is delayed to line up with the pixel pipeline and the
// upstream layer latency; colour is forced to black while delayed blanking is
// active.
// Ports:
//   clk, rst            - system clock, asynchronous active-high reset
//   pxl_cen             - pixel clock enable (one clk pulse per pixel)
//   obj_pxl, scr_pxl    - 4-bit object / scroll colour indices (obj 0 = transparent)
//   LHBL, LVBL          - active-low horizontal / vertical blanking
//   prog_data/addr/en   - PROM download port, one byte per clk
//   gfx_en              - debug layer enables ([0] scroll, [3] object)
//   red, green, blue    - 4-bit pixel colour
//   LHBL_dly, LVBL_dly  - blanking delayed by BLANK_DLY pixel ticks
module jttrack_colmix
    import jttrack_pkg::*;
#(
    parameter int BLANK_DLY = 9
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                pxl_cen,
    input  logic [3:0]          obj_pxl,
    input  logic [3:0]          scr_pxl,
    input  logic                LHBL,
    input  logic                LVBL,
    input  logic [PAL_DW-1:0]   prog_data,
    input  logic [PAL_AW-1:0]   prog_addr,
    input  logic                prog_en,
    input  logic [3:0]          gfx_en,
    output logic [3:0]          red,
    output logic [3:0]          green,
    output logic [3:0]          blue,
    output logic                LHBL_dly,
    output logic                LVBL_dly
);

    generate
        if (BLANK_DLY < 1 || BLANK_DLY > 15) begin : g_bad_dly
            $error("jttrack_colmix: BLANK_DLY must be in 1..15");
        end
    endgenerate

    logic [3:0]        obj_m_s;
    logic [3:0]        scr_m_s;
    logic [PAL_AW-1:0] addr_d;
    logic [PAL_AW-1:0] addr_q;
    logic [PAL_DW-1:0] pal_mem [0:(1<<PAL_AW)-1];
    logic [PAL_DW-1:0] pal_q;
    logic [3:0]        red_d, green_d, blue_d;
    logic [3:0]        red_q, green_q, blue_q;
    logic [1:0]        blank_dly_s;
    logic              unused_gfx_s;

    assign unused_gfx_s = ^gfx_en[2:1];

    // Layer masking and priority: any visible object pixel beats the scroll
    always_comb begin
        obj_m_s = gfx_en[GFX_OBJ] ? obj_pxl : 4'd0;
        scr_m_s = gfx_en[GFX_SCR] ? scr_pxl : 4'd0;
        addr_d  = {1'b0, scr_m_s};
        if (obj_m_s != 4'd0) begin
            addr_d          = {1'b0, obj_m_s};
            addr_d[OBJ_BIT] = 1'b1;
        end else begin
            addr_d = {1'b0, scr_m_s};
        end
    end

    // Stage 1: register the palette address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q <= '0;
        end else if (pxl_cen) begin
            addr_q <= addr_d;
        end
    end

    // Palette download: free-running on clk, not cleared by reset
    always_ff @(posedge clk) begin
        if (prog_en) begin
            pal_mem[prog_addr] <= prog_data;
        end
    end

    // Stage 2: synchronous palette read; a same-edge write is not visible yet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pal_q <= '0;
        end else if (pxl_cen) begin
            pal_q <= pal_mem[addr_q];
        end
    end

    jtframe_sh #(
        .W (2),
        .L (BLANK_DLY)
    ) u_blank_sh (
        .clk_i  (clk),
        .rst_i  (rst),
        .cen_i  (pxl_cen),
        .din_i  ({LHBL, LVBL}),
        .drop_o (blank_dly_s)
    );

    // Expansion and blanking gate, using the delayed blanking as it is now
    always_comb begin
        if (blank_dly_s[1] & blank_dly_s[0]) begin
            red_d   = expand3(pal_q[R_LSB +: 3]);
            green_d = expand3(pal_q[G_LSB +: 3]);
            blue_d  = expand2(pal_q[B_LSB +: 2]);
        end else begin
            red_d   = 4'd0;
            green_d = 4'd0;
            blue_d  = 4'd0;
        end
    end

    // Stage 3: registered colour outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            red_q   <= 4'd0;
            green_q <= 4'd0;
            blue_q  <= 4'd0;
        end else if (pxl_cen) begin
            red_q   <= red_d;
            green_q <= green_d;
            blue_q  <= blue_d;
        end
    end

    assign red      = red_q;
    assign green    = green_q;
    assign blue     = blue_q;
    assign LHBL_dly = blank_dly_s[1];
    assign LVBL_dly = blank_dly_s[0];

endmodule

// File: tb/tb_jttrack_colmix.sv
module tb_jttrack_colmix;

    localparam int D = 9;

    logic       clk;
    logic       rst;
    logic       pxl_cen;
    logic [3:0] obj_pxl;
    logic [3:0] scr_pxl;
    logic       LHBL;
    logic       LVBL;
    logic [7:0] prog_data;
    logic [4:0] prog_addr;
    logic       prog_en;
    logic [3:0] gfx_en;
    logic [3:0] red, green, blue;
    logic       LHBL_dly, LVBL_dly;

    jttrack_colmix #(.BLANK_DLY(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .pxl_cen   (pxl_cen),
        .obj_pxl   (obj_pxl),
        .scr_pxl   (scr_pxl),
        .LHBL      (LHBL),
        .LVBL      (LVBL),
        .prog_data (prog_data),
        .prog_addr (prog_addr),
        .prog_en   (prog_en),
        .gfx_en    (gfx_en),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .LHBL_dly  (LHBL_dly),
        .LVBL_dly  (LVBL_dly)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] r;
        logic [3:0] g;
        logic [3:0] b;
        logic       hd;
        logic       vd;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    // Reference model: per-tick history of address, blanking and palette read
    logic [7:0] mdl_mem [0:31];
    logic [4:0] a_h  [0:4095];
    logic [1:0] b_h  [0:4095];
    logic [7:0] rd_h [0:4095];
    int         k;

    function automatic logic [4:0] get_a(input int i);
        return (i < 1) ? 5'd0 : a_h[i];
    endfunction
    function automatic logic [1:0] get_b(input int i);
        return (i < 1) ? 2'b00 : b_h[i];
    endfunction
    function automatic logic [7:0] get_rd(input int i);
        return (i < 1) ? 8'h00 : rd_h[i];
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endtask

    task automatic check_rgb(input string name, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        check(name, {20'd0, red, green, blue}, {20'd0, r, g, b});
    endtask

    task automatic prog_write(input logic [4:0] a, input logic [7:0] d);
        prog_en   = 1'b1;
        prog_addr = a;
        prog_data = d;
        mdl_mem[a] = d;
        @(posedge clk);
        @(negedge clk);
        prog_en = 1'b0;
    endtask

    task automatic tick(input logic [3:0] obj, input logic [3:0] scr, input logic [3:0] gfx,
                        input logic hb, input logic vb,
                        input logic do_wr, input logic [4:0] wa, input logic [7:0] wd);
        logic [3:0] om, sm;
        logic [7:0] pal;
        logic [1:0] gb, ob;
        exp_t       e;
        obj_pxl   = obj;
        scr_pxl   = scr;
        gfx_en    = gfx;
        LHBL      = hb;
        LVBL      = vb;
        prog_en   = do_wr;
        prog_addr = wa;
        prog_data = wd;
        pxl_cen   = 1'b1;
        k++;
        om = gfx[3] ? obj : 4'd0;
        sm = gfx[0] ? scr : 4'd0;
        a_h[k]  = (om != 4'd0) ? {1'b1, om} : {1'b0, sm};
        b_h[k]  = {hb, vb};
        rd_h[k] = mdl_mem[get_a(k-1)];
        if (do_wr) mdl_mem[wa] = wd;
        pal = get_rd(k-1);
        gb  = get_b(k-D);
        ob  = get_b(k-D+1);
        e.hd = ob[1];
        e.vd = ob[0];
        if (gb == 2'b11) begin
            e.r = {pal[2:0], pal[2]};
            e.g = {pal[5:3], pal[5]};
            e.b = {pal[7:6], pal[7:6]};
        end else begin
            e.r = 4'd0;
            e.g = 4'd0;
            e.b = 4'd0;
        end
        sb_q.push_back(e);
        @(posedge clk);
        @(negedge clk);
        pxl_cen = 1'b0;
        prog_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run(input int n, input logic [3:0] obj, input logic [3:0] scr, input logic [3:0] gfx);
        for (int i = 0; i < n; i++) tick(obj, scr, gfx, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
    endtask

    // Monitor: every pixel tick, compare the outputs against the scoreboard head
    always @(posedge clk) begin
        if (pxl_cen && !rst) begin
            @(negedge clk);
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_empty: output tick with no expected entry at %0t", $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("sb_pixel", {18'd0, red, green, blue, LHBL_dly, LVBL_dly},
                      {18'd0, mon_e.r, mon_e.g, mon_e.b, mon_e.hd, mon_e.vd});
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; pxl_cen = 1'b0; obj_pxl = 4'd0; scr_pxl = 4'd0;
        LHBL = 1'b0; LVBL = 1'b0; prog_data = 8'd0; prog_addr = 5'd0;
        prog_en = 1'b0; gfx_en = 4'hF; k = 0;
        repeat (3) @(negedge clk);
        check_rgb("reset_rgb", 4'd0, 4'd0, 4'd0);
        check("reset_dly", {30'd0, LHBL_dly, LVBL_dly}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 32; i++) prog_write(5'(i), 8'(i * 37 + 1));
        prog_write(5'h15, 8'hFF);
        prog_write(5'h03, 8'h00);
        prog_write(5'h02, 8'h9D);
        prog_write(5'h00, 8'h5A);
        prog_write(5'h07, 8'h38);

        // First BLANK_DLY ticks after reset are black
        for (int i = 1; i <= 12; i++) begin
            tick(4'd0, 4'd2, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
            if (i <= D) check_rgb("post_reset_blank", 4'd0, 4'd0, 4'd0);
            else        check_rgb("post_reset_live", 4'hB, 4'h6, 4'hA);
        end

        // Priority
        run(3, 4'd5, 4'd3, 4'hF);
        check_rgb("prio_obj", 4'hF, 4'hF, 4'hF);
        run(3, 4'd0, 4'd3, 4'hF);
        check_rgb("prio_scr", 4'h0, 4'h0, 4'h0);

        // Expansion
        run(3, 4'd0, 4'd2, 4'hF);
        check_rgb("expand", 4'hB, 4'h6, 4'hA);

        // Layer masks
        run(3, 4'd5, 4'd3, 4'h0);
        check_rgb("mask_none", 4'h4, 4'h6, 4'h5);
        run(3, 4'd5, 4'd3, 4'h8);
        check_rgb("mask_obj_pass", 4'hF, 4'hF, 4'hF);
        run(3, 4'd0, 4'd3, 4'h8);
        check_rgb("mask_scr_zero", 4'h4, 4'h6, 4'h5);

        // Blank delay: single-tick LHBL pulse
        run(3, 4'd0, 4'd2, 4'hF);
        for (int i = 0; i <= D + 2; i++) begin
            tick(4'd0, 4'd2, 4'hF, (i != 0), 1'b1, 1'b0, 5'd0, 8'd0);
            check("blank_hd", {31'd0, LHBL_dly}, {31'd0, (i != D - 1)});
            check("blank_vd", {31'd0, LVBL_dly}, 32'd1);
            if (i == D) check_rgb("blank_rgb_off", 4'd0, 4'd0, 4'd0);
            else        check_rgb("blank_rgb_on", 4'hB, 4'h6, 4'hA);
        end

        // Write during read of the same address
        tick(4'd0, 4'd7, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
        tick(4'd0, 4'd7, 4'hF, 1'b1, 1'b1, 1'b1, 5'd7, 8'h07);
        tick(4'd0, 4'd7, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
        check_rgb("wdr_old", 4'h0, 4'hF, 4'h0);
        tick(4'd0, 4'd7, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
        check_rgb("wdr_new", 4'hF, 4'h0, 4'h0);

        // Reset asserted mid-line clears outputs without a clock edge
        #2;
        rst = 1'b1;
        #1;
        check_rgb("midline_rst_rgb", 4'd0, 4'd0, 4'd0);
        check("midline_rst_dly", {30'd0, LHBL_dly, LVBL_dly}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int i = 1; i <= D + 2; i++) begin
            tick(4'd0, 4'd2, 4'hF, 1'b1, 1'b1, 1'b0, 5'd0, 8'd0);
            if (i <= D) check_rgb("rerst_blank", 4'd0, 4'd0, 4'd0);
            else        check_rgb("rerst_live", 4'hB, 4'h6, 4'hA);
        end

        repeat (2) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
